// File: rtl/matrix_row_scan_ctrl.sv
// Row-scan sequencer for an 8x8 LED matrix: fetch a row pattern, light it for a dwell time, blank, advance.
// Optional PWM dimming is compiled in with `define ROWSCAN_DIMMING_EN (adds ROWSCAN_Brightness_In).
module matrix_row_scan_ctrl #(
    parameter int DATAWIDTH_SELECTOR = 3,
    parameter int DATAWIDTH_DATA     = 8,
    parameter int DWELL_CYCLES       = 1000,
    parameter int BLANK_CYCLES       = 4,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          ROWSCAN_CLOCK_50,
    input  logic                          ROWSCAN_RESET_InHigh,
    input  logic                          ROWSCAN_Enable_In,
    output logic                          ROWSCAN_RdReq_Out,
    output logic [DATAWIDTH_SELECTOR-1:0] ROWSCAN_RdAddr_Out,
    input  logic [DATAWIDTH_DATA-1:0]     ROWSCAN_RdData_In,
    input  logic                          ROWSCAN_RdValid_In,
`ifdef ROWSCAN_DIMMING_EN
    input  logic [2:0]                    ROWSCAN_Brightness_In,
`endif
    output logic [DATAWIDTH_SELECTOR-1:0] ROWSCAN_RowSelect_Out,
    output logic                          ROWSCAN_RowEnable_Out,
    output logic [DATAWIDTH_DATA-1:0]     ROWSCAN_ColData_Out,
    output logic                          ROWSCAN_FrameDone_Out,
    output logic                          ROWSCAN_Busy_Out
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DISPLAY, S_BLANK} state_t;

    localparam logic [CNT_WIDTH-1:0] DWELL_LAST = CNT_WIDTH'(DWELL_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] BLANK_LAST = CNT_WIDTH'(BLANK_CYCLES - 1);

    state_t                          state_q, state_d;
    logic [DATAWIDTH_SELECTOR-1:0]   row_q, row_d;
    logic [CNT_WIDTH-1:0]            cnt_q, cnt_d;
    logic [DATAWIDTH_DATA-1:0]       data_q, data_d;

    logic                            rdreq_q, rdreq_d;
    logic                            rowen_q, rowen_d;
    logic [DATAWIDTH_DATA-1:0]       coldata_q, coldata_d;
    logic                            framedone_q, framedone_d;
    logic                            busy_q, busy_d;
    logic                            show_d;
    logic                            blank_last;

`ifdef ROWSCAN_DIMMING_EN
    logic [2:0]                      phase_q, phase_d;
`endif

    assign blank_last = (state_q == S_BLANK) && (cnt_q == BLANK_LAST);

    always_ff @(posedge ROWSCAN_CLOCK_50) begin
        if (ROWSCAN_RESET_InHigh) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            rdreq_q     <= 1'b0;
            rowen_q     <= 1'b0;
            coldata_q   <= '0;
            framedone_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ROWSCAN_DIMMING_EN
            phase_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            rdreq_q     <= rdreq_d;
            rowen_q     <= rowen_d;
            coldata_q   <= coldata_d;
            framedone_q <= framedone_d;
            busy_q      <= busy_d;
`ifdef ROWSCAN_DIMMING_EN
            phase_q     <= phase_d;
`endif
        end
    end

    // Enable is only looked at in IDLE and on the last BLANK cycle, so a started row always completes.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
`ifdef ROWSCAN_DIMMING_EN
        phase_d = phase_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ROWSCAN_Enable_In) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (rdreq_q && ROWSCAN_RdValid_In) begin
                    data_d  = ROWSCAN_RdData_In;
                    cnt_d   = '0;
                    state_d = S_DISPLAY;
`ifdef ROWSCAN_DIMMING_EN
                    phase_d = '0;
`endif
                end
            end
            S_DISPLAY: begin
`ifdef ROWSCAN_DIMMING_EN
                phase_d = phase_q + 3'd1;
`endif
                if (cnt_q == DWELL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_BLANK;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_BLANK: begin
                if (blank_last) begin
                    cnt_d   = '0;
                    row_d   = row_q + 1'b1;
                    state_d = ROWSCAN_Enable_In ? S_FETCH : S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with the state register.
    always_comb begin
        rdreq_d     = (state_d == S_FETCH);
        rowen_d     = (state_d == S_DISPLAY);
        busy_d      = (state_d != S_IDLE);
        framedone_d = blank_last && (row_q == '1);
`ifdef ROWSCAN_DIMMING_EN
        show_d      = rowen_d && (phase_d <= ROWSCAN_Brightness_In);
`else
        show_d      = rowen_d;
`endif
    end

    for (genvar gi = 0; gi < DATAWIDTH_DATA; gi++) begin : g_col
        assign coldata_d[gi] = data_d[gi] & show_d;
    end

    assign ROWSCAN_RdReq_Out     = rdreq_q;
    assign ROWSCAN_RdAddr_Out    = row_q;
    assign ROWSCAN_RowSelect_Out = row_q;
    assign ROWSCAN_RowEnable_Out = rowen_q;
    assign ROWSCAN_ColData_Out   = coldata_q;
    assign ROWSCAN_FrameDone_Out = framedone_q;
    assign ROWSCAN_Busy_Out      = busy_q;

endmodule

// File: tb/tb_matrix_row_scan_ctrl.sv
// Testbench for matrix_row_scan_ctrl with DWELL_CYCLES=8, BLANK_CYCLES=2 and a framebuffer model feeding a scoreboard.
// Define ROWSCAN_DIMMING_EN for both files to also exercise the PWM dimming scenario.
module tb_matrix_row_scan_ctrl;

    localparam int DWELL = 8;
    localparam int BLANK = 2;

    typedef struct {
        logic [2:0] row;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic       en = 1'b0;
    logic       rd_req;
    logic [2:0] rd_addr;
    logic [7:0] rd_data = 8'h00;
    logic       rd_valid = 1'b0;
    logic [2:0] row_sel;
    logic       row_en;
    logic [7:0] col_data;
    logic       frame_done;
    logic       busy;
`ifdef ROWSCAN_DIMMING_EN
    logic [2:0] bright = 3'd7;
`endif

    logic [7:0] fb [8];
    exp_t       sb_q [$];
    int         mem_delay = 0;
    int         wait_cnt  = 0;
    bit         mem_auto  = 1'b1;
    int         checks    = 0;
    int         fails     = 0;

    matrix_row_scan_ctrl #(
        .DATAWIDTH_SELECTOR (3),
        .DATAWIDTH_DATA     (8),
        .DWELL_CYCLES       (DWELL),
        .BLANK_CYCLES       (BLANK),
        .CNT_WIDTH          (16)
    ) dut (
        .ROWSCAN_CLOCK_50      (clk),
        .ROWSCAN_RESET_InHigh  (srst),
        .ROWSCAN_Enable_In     (en),
        .ROWSCAN_RdReq_Out     (rd_req),
        .ROWSCAN_RdAddr_Out    (rd_addr),
        .ROWSCAN_RdData_In     (rd_data),
        .ROWSCAN_RdValid_In    (rd_valid),
`ifdef ROWSCAN_DIMMING_EN
        .ROWSCAN_Brightness_In (bright),
`endif
        .ROWSCAN_RowSelect_Out (row_sel),
        .ROWSCAN_RowEnable_Out (row_en),
        .ROWSCAN_ColData_Out   (col_data),
        .ROWSCAN_FrameDone_Out (frame_done),
        .ROWSCAN_Busy_Out      (busy)
    );

    always #5 clk = ~clk;

    // One clock; afterwards the framebuffer model answers a pending request after mem_delay idle cycles.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        if (mem_auto) begin
            if (rd_req) begin
                if (wait_cnt >= mem_delay) begin
                    rd_valid = 1'b1;
                    rd_data  = fb[rd_addr];
                    e.row    = rd_addr;
                    e.data   = fb[rd_addr];
                    sb_q.push_back(e);
                    wait_cnt = 0;
                end else begin
                    rd_valid = 1'b0;
                    rd_data  = 8'h00;
                    wait_cnt++;
                end
            end else begin
                rd_valid = 1'b0;
                wait_cnt = 0;
            end
        end
    endtask

    task automatic do_reset();
        srst      = 1'b1;
        en        = 1'b0;
        mem_auto  = 1'b1;
        mem_delay = 0;
        cycle();
        cycle();
        srst = 1'b0;
        sb_q.delete();
        wait_cnt = 0;
    endtask

    task automatic wait_lit(input logic [2:0] r, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (row_en && row_sel == r) begin
                ok = 1'b1;
                return;
            end
            cycle();
        end
    endtask

    task automatic test_reset();
        srst = 1'b1;
        en   = 1'b0;
        cycle();
        cycle();
        checks++; if (rd_req !== 1'b0) begin fails++; $display("FAIL reset_rdreq: got %b expected 0", rd_req); end
        checks++; if (row_en !== 1'b0) begin fails++; $display("FAIL reset_rowen: got %b expected 0", row_en); end
        checks++; if (col_data !== 8'h00) begin fails++; $display("FAIL reset_coldata: got %h expected 00", col_data); end
        checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_framedone: got %b expected 0", frame_done); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (row_sel !== 3'd0) begin fails++; $display("FAIL reset_rowsel: got %0d expected 0", row_sel); end
        $display("reset: rdreq=%b rowen=%b col=%h busy=%b sel=%0d", rd_req, row_en, col_data, busy, row_sel);
        srst = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_first_row();
        exp_t e;
        int   lit;
        int   blank;
        do_reset();
        fb[0] = 8'hA5;
        fb[1] = 8'h3C;
        en = 1'b1;
        cycle();
        checks++; if (rd_req !== 1'b1 || rd_addr !== 3'd0) begin fails++; $display("FAIL first_fetch: got req=%b addr=%0d expected req=1 addr=0", rd_req, rd_addr); end
        checks++; if (row_en !== 1'b0) begin fails++; $display("FAIL first_fetch_rowen: got %b expected 0", row_en); end
        cycle();
        checks++;
        if (sb_q.size() == 0) begin
            fails++; $display("FAIL first_sb: got empty scoreboard expected one fetch");
        end else begin
            e = sb_q.pop_front();
            if (row_en !== 1'b1 || row_sel !== e.row || col_data !== e.data) begin
                fails++; $display("FAIL first_display: got en=%b sel=%0d col=%h expected en=1 sel=%0d col=%h", row_en, row_sel, col_data, e.row, e.data);
            end
        end
        lit = 0;
        while (row_en && lit < 20) begin
            checks++; if (col_data !== 8'hA5 || row_sel !== 3'd0) begin fails++; $display("FAIL first_lit: got sel=%0d col=%h expected sel=0 col=a5", row_sel, col_data); end
            lit++;
            cycle();
        end
        checks++; if (lit != DWELL) begin fails++; $display("FAIL first_dwell: got %0d cycles expected %0d", lit, DWELL); end
        blank = 0;
        while (!row_en && !rd_req && busy && blank < 20) begin
            checks++; if (col_data !== 8'h00) begin fails++; $display("FAIL first_blank_col: got %h expected 00", col_data); end
            blank++;
            cycle();
        end
        checks++; if (blank != BLANK) begin fails++; $display("FAIL first_blank_len: got %0d expected %0d", blank, BLANK); end
        checks++; if (rd_req !== 1'b1 || rd_addr !== 3'd1) begin fails++; $display("FAIL next_fetch: got req=%b addr=%0d expected req=1 addr=1", rd_req, rd_addr); end
        $display("first_row: lit=%0d blank=%0d next_addr=%0d", lit, blank, rd_addr);
        do_reset();
    endtask

    task automatic test_frame();
        exp_t       e;
        int         rows_seen  = 0;
        int         nr         = 0;
        int         pulses     = 0;
        int         last_pulse = -1;
        logic       prev_en    = 1'b0;
        logic       prev_fd    = 1'b0;
        logic [2:0] prev_sel   = 3'd0;
        logic [7:0] want;
        do_reset();
        for (int r = 0; r < 8; r++) fb[r] = 8'h01 << r;
        en = 1'b1;
        for (int c = 0; c < 200; c++) begin
            cycle();
            if (row_en && !prev_en) begin
                want = 8'h01 << nr;
                checks++;
                if (sb_q.size() == 0) begin
                    fails++; $display("FAIL frame_sb: row %0d lit with empty scoreboard", row_sel);
                end else begin
                    e = sb_q.pop_front();
                    if (row_sel !== e.row || col_data !== e.data) begin
                        fails++; $display("FAIL frame_sb_row: got sel=%0d col=%h expected sel=%0d col=%h", row_sel, col_data, e.row, e.data);
                    end
                end
                checks++;
                if (row_sel !== 3'(nr) || col_data !== want) begin
                    fails++; $display("FAIL frame_order: got sel=%0d col=%h expected sel=%0d col=%h", row_sel, col_data, nr, want);
                end
                $display("frame: row %0d sel=%0d col=%h", rows_seen, row_sel, col_data);
                nr = (nr + 1) % 8;
                rows_seen++;
            end
            if (row_sel !== prev_sel) begin
                checks++;
                if (row_en || prev_en) begin fails++; $display("FAIL frame_sel_while_lit: got sel %0d->%0d with en=%b expected en=0", prev_sel, row_sel, row_en); end
            end
            if (frame_done) begin
                checks++;
                if (prev_fd) begin fails++; $display("FAIL frame_pulse_width: got framedone high for 2+ cycles expected 1"); end
                if (!prev_fd) begin
                    pulses++;
                    checks++;
                    if (row_sel !== 3'd0 || row_en !== 1'b0) begin fails++; $display("FAIL frame_pulse_row: got sel=%0d en=%b expected sel=0 en=0", row_sel, row_en); end
                    if (last_pulse >= 0) begin
                        checks++;
                        if (c - last_pulse != 8 * (1 + DWELL + BLANK)) begin fails++; $display("FAIL frame_period: got %0d expected %0d", c - last_pulse, 8 * (1 + DWELL + BLANK)); end
                    end
                    last_pulse = c;
                end
            end
            prev_en  = row_en;
            prev_fd  = frame_done;
            prev_sel = row_sel;
        end
        checks++; if (pulses != 2) begin fails++; $display("FAIL frame_pulses: got %0d expected 2", pulses); end
        checks++; if (rows_seen < 16) begin fails++; $display("FAIL frame_rows: got %0d expected at least 16", rows_seen); end
        do_reset();
    endtask

    task automatic test_fetch_wait();
        exp_t e;
        int   low = 0;
        do_reset();
        fb[0] = 8'h5A;
        mem_delay = 5;
        en = 1'b1;
        cycle();
        while (rd_req && !rd_valid && low < 50) begin
            checks++;
            if (rd_addr !== 3'd0 || row_en !== 1'b0) begin fails++; $display("FAIL wait_hold: got addr=%0d en=%b expected addr=0 en=0", rd_addr, row_en); end
            low++;
            cycle();
        end
        checks++; if (low != 5) begin fails++; $display("FAIL wait_len: got %0d cycles expected 5", low); end
        checks++; if (rd_req !== 1'b1 || rd_valid !== 1'b1) begin fails++; $display("FAIL wait_valid: got req=%b valid=%b expected 1 1", rd_req, rd_valid); end
        cycle();
        checks++;
        if (sb_q.size() == 0) begin
            fails++; $display("FAIL wait_sb: got empty scoreboard expected one fetch");
        end else begin
            e = sb_q.pop_front();
            if (row_en !== 1'b1 || col_data !== e.data || row_sel !== e.row) begin
                fails++; $display("FAIL wait_display: got en=%b sel=%0d col=%h expected en=1 sel=%0d col=%h", row_en, row_sel, col_data, e.row, e.data);
            end
        end
        $display("fetch_wait: low=%0d then en=%b col=%h", low, row_en, col_data);
        do_reset();
    endtask

    task automatic test_enable_drop();
        bit ok;
        int lit;
        int blank = 0;
        do_reset();
        for (int r = 0; r < 8; r++) fb[r] = 8'h10 + 8'(r);
        en = 1'b1;
        wait_lit(3'd3, ok);
        checks++; if (!ok) begin fails++; $display("FAIL drop_reach_row3: got timeout expected row 3 lit"); end
        lit = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (row_en) lit++;
        end
        en = 1'b0;
        for (int n = 0; n < 20 && row_en; n++) begin
            cycle();
            if (row_en) lit++;
        end
        checks++; if (lit != DWELL) begin fails++; $display("FAIL drop_dwell: got %0d expected %0d", lit, DWELL); end
        while (busy && !row_en && blank < 20) begin
            blank++;
            cycle();
        end
        checks++; if (blank != BLANK) begin fails++; $display("FAIL drop_blank: got %0d expected %0d", blank, BLANK); end
        checks++; if (busy !== 1'b0 || rd_req !== 1'b0) begin fails++; $display("FAIL drop_idle: got busy=%b req=%b expected 0 0", busy, rd_req); end
        checks++; if (row_sel !== 3'd4) begin fails++; $display("FAIL drop_row: got %0d expected 4", row_sel); end
        cycle();
        cycle();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL drop_stay_idle: got busy=%b expected 0", busy); end
        en = 1'b1;
        cycle();
        checks++; if (rd_req !== 1'b1 || rd_addr !== 3'd4) begin fails++; $display("FAIL drop_refetch: got req=%b addr=%0d expected req=1 addr=4", rd_req, rd_addr); end
        $display("enable_drop: lit=%0d blank=%0d resumed addr=%0d", lit, blank, rd_addr);
        do_reset();
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        for (int r = 0; r < 8; r++) fb[r] = 8'hC0 + 8'(r);
        en = 1'b1;
        wait_lit(3'd5, ok);
        checks++; if (!ok) begin fails++; $display("FAIL rmid_reach_row5: got timeout expected row 5 lit"); end
        cycle();
        cycle();
        srst = 1'b1;
        en   = 1'b0;
        cycle();
        checks++;
        if (rd_req !== 1'b0 || row_en !== 1'b0 || col_data !== 8'h00 || frame_done !== 1'b0 || busy !== 1'b0 || row_sel !== 3'd0) begin
            fails++; $display("FAIL rmid_outputs: got req=%b en=%b col=%h fd=%b busy=%b sel=%0d expected all 0", rd_req, row_en, col_data, frame_done, busy, row_sel);
        end
        srst     = 1'b0;
        mem_auto = 1'b0;
        rd_valid = 1'b1;
        rd_data  = 8'h3C;
        cycle();
        rd_valid = 1'b0;
        cycle();
        checks++;
        if (busy !== 1'b0 || row_en !== 1'b0 || col_data !== 8'h00 || rd_req !== 1'b0) begin
            fails++; $display("FAIL rmid_late_valid: got busy=%b en=%b col=%h req=%b expected all 0", busy, row_en, col_data, rd_req);
        end
        $display("reset_mid: busy=%b en=%b col=%h", busy, row_en, col_data);
        do_reset();
    endtask

`ifdef ROWSCAN_DIMMING_EN
    task automatic test_dimming();
        bit         ok;
        logic [7:0] want;
        do_reset();
        for (int r = 0; r < 8; r++) fb[r] = 8'hFF;
        bright = 3'd3;
        en = 1'b1;
        wait_lit(3'd0, ok);
        checks++; if (!ok) begin fails++; $display("FAIL dim_reach_row0: got timeout expected row 0 lit"); end
        for (int k = 0; k < DWELL; k++) begin
            want = (k <= 3) ? 8'hFF : 8'h00;
            checks++;
            if (row_en !== 1'b1 || col_data !== want) begin fails++; $display("FAIL dim3_cycle%0d: got en=%b col=%h expected en=1 col=%h", k, row_en, col_data, want); end
            cycle();
        end
        bright = 3'd7;
        wait_lit(3'd1, ok);
        checks++; if (!ok) begin fails++; $display("FAIL dim_reach_row1: got timeout expected row 1 lit"); end
        for (int k = 0; k < DWELL; k++) begin
            checks++;
            if (row_en !== 1'b1 || col_data !== 8'hFF) begin fails++; $display("FAIL dim7_cycle%0d: got en=%b col=%h expected en=1 col=ff", k, row_en, col_data); end
            cycle();
        end
        $display("dimming: brightness 3 and 7 rows displayed");
        do_reset();
    endtask
`endif

    initial begin
        for (int r = 0; r < 8; r++) fb[r] = 8'h00;
        test_reset();
        test_first_row();
        test_frame();
        test_fetch_wait();
        test_enable_drop();
        test_reset_mid();
`ifdef ROWSCAN_DIMMING_EN
        test_dimming();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
